// File: rtl/prio_object_ctrl.sv
// Priority-arbitrated on/off controller for N_OBJ objects with per-object ownership hold timers.
// Outputs are registered: a request sampled on one rising edge is answered on that same edge's register update.
module prio_object_ctrl #(
    parameter int N_OBJ    = 5,
    parameter int LP_W     = 2,
    parameter int HOLD_CYC = 16,
    localparam int OBJ_W   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1,
    localparam int ST_W    = 2 + LP_W
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    en_i,
    input  logic [OBJ_W-1:0]        object_number_i,
    input  logic [LP_W-1:0]         lp_i,
    input  logic                    command_i,
    input  logic                    force_off_i,
    output logic                    ack_o,
    output logic                    nack_o,
    output logic                    err_o,
    output logic [N_OBJ*ST_W-1:0]   status_o
);

    localparam int CNT_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam int IDX_N = 1 << OBJ_W;
    localparam logic [IDX_N-1:0] IDX_OK  = {IDX_N{1'b1}} >> (IDX_N - N_OBJ);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC);

    logic [N_OBJ-1:0] on_q, on_d;
    logic [LP_W-1:0]  owner_q [N_OBJ];
    logic [LP_W-1:0]  owner_d [N_OBJ];
    logic [CNT_W-1:0] cnt_q   [N_OBJ];
    logic [CNT_W-1:0] cnt_d   [N_OBJ];
    logic             ack_q, nack_q, err_q;
    logic             ack_d, nack_d, err_d;
    logic [N_OBJ-1:0] busy;
    logic             in_range;
    logic             req_ok;
    logic             accept;

    always_comb begin
        for (int k = 0; k < N_OBJ; k++) begin
            busy[k] = (cnt_q[k] != '0);
        end
    end

    // Owner clears on the edge the counter reaches zero; with no hold it lasts exactly one cycle.
    always_comb begin
        in_range = IDX_OK[object_number_i];
        req_ok   = en_i && in_range && !force_off_i;
        accept   = 1'b0;
        on_d     = on_q;
        for (int k = 0; k < N_OBJ; k++) begin
            owner_d[k] = owner_q[k];
            cnt_d[k]   = cnt_q[k];
            if (force_off_i) begin
                on_d[k]    = 1'b0;
                owner_d[k] = '0;
                cnt_d[k]   = '0;
            end else if (req_ok && (object_number_i == OBJ_W'(k))
                         && (!busy[k] || (lp_i >= owner_q[k]))) begin
                accept     = 1'b1;
                on_d[k]    = command_i;
                owner_d[k] = lp_i;
                cnt_d[k]   = HOLD_LD;
            end else begin
                if (busy[k]) begin
                    cnt_d[k] = cnt_q[k] - CNT_W'(1);
                end
                if (cnt_q[k] <= CNT_W'(1)) begin
                    owner_d[k] = '0;
                end
            end
        end
        ack_d  = accept;
        nack_d = en_i && !accept;
        err_d  = en_i && !in_range;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            on_q   <= '0;
            ack_q  <= 1'b0;
            nack_q <= 1'b0;
            err_q  <= 1'b0;
            for (int k = 0; k < N_OBJ; k++) begin
                owner_q[k] <= '0;
                cnt_q[k]   <= '0;
            end
        end else begin
            on_q   <= on_d;
            ack_q  <= ack_d;
            nack_q <= nack_d;
            err_q  <= err_d;
            for (int k = 0; k < N_OBJ; k++) begin
                owner_q[k] <= owner_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    always_comb begin
        status_o = '0;
        for (int k = 0; k < N_OBJ; k++) begin
            status_o[k*ST_W +: ST_W] = {owner_q[k], busy[k], on_q[k]};
        end
    end

    assign ack_o  = ack_q;
    assign nack_o = nack_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_prio_object_ctrl.sv
// Scoreboard bench for prio_object_ctrl: directed vectors on the default build and
// a modelled random run on an 8-object, 3-bit priority, zero-hold build.
module tb_prio_object_ctrl;

    typedef struct {
        logic [2:0]  pulses;
        logic [63:0] status;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic        en5 = 1'b0, cmd5 = 1'b0, frc5 = 1'b0;
    logic [2:0]  obj5 = '0;
    logic [1:0]  lp5 = '0;
    logic        ack5, nack5, err5;
    logic [19:0] status5;

    logic        en8 = 1'b0, cmd8 = 1'b0, frc8 = 1'b0;
    logic [2:0]  obj8 = '0;
    logic [2:0]  lp8 = '0;
    logic        ack8, nack8, err8;
    logic [39:0] status8;

    exp_t q5[$];
    exp_t q8[$];
    exp_t e5, e8;
    int   nChecks = 0;
    int   nMiscompares = 0;

    logic [7:0]  mOn = '0;
    logic [2:0]  mOwn [8];

    prio_object_ctrl dut (
        .clk_i(clk), .rstn_i(rstn), .en_i(en5), .object_number_i(obj5), .lp_i(lp5),
        .command_i(cmd5), .force_off_i(frc5), .ack_o(ack5), .nack_o(nack5),
        .err_o(err5), .status_o(status5)
    );

    prio_object_ctrl #(.N_OBJ(8), .LP_W(3), .HOLD_CYC(0)) dut8 (
        .clk_i(clk), .rstn_i(rstn), .en_i(en8), .object_number_i(obj8), .lp_i(lp8),
        .command_i(cmd8), .force_off_i(frc8), .ack_o(ack8), .nack_o(nack8),
        .err_o(err8), .status_o(status8)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of the default-build DUT and queues the hand-computed response.
    task automatic applyStimulus(input logic r, input logic en, input logic [2:0] obj,
                                 input logic [1:0] lp, input logic cmd, input logic frc,
                                 input logic [2:0] pulses, input logic [19:0] st);
        exp_t e;
        @(negedge clk);
        rstn = r; en5 = en; obj5 = obj; lp5 = lp; cmd5 = cmd; frc5 = frc;
        e.pulses = pulses;
        e.status = {44'b0, st};
        q5.push_back(e);
    endtask

    task automatic applyRandom8(input logic en, input logic [2:0] obj, input logic [2:0] lp,
                                input logic cmd, input logic frc);
        exp_t e;
        logic [39:0] st;
        @(negedge clk);
        en8 = en; obj8 = obj; lp8 = lp; cmd8 = cmd; frc8 = frc;
        for (int k = 0; k < 8; k++) mOwn[k] = '0;
        if (frc) begin
            mOn = '0;
            e.pulses = {1'b0, en, 1'b0};
        end else if (en) begin
            mOn[obj] = cmd;
            mOwn[obj] = lp;
            e.pulses = 3'b100;
        end else begin
            e.pulses = 3'b000;
        end
        st = '0;
        for (int k = 0; k < 8; k++) st[k*5 +: 5] = {mOwn[k], 1'b0, mOn[k]};
        e.status = {24'b0, st};
        q8.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (q5.size() > 0) begin
            e5 = q5.pop_front();
            checkOutput("pulses5", {61'b0, ack5, nack5, err5}, e5.pulses);
            checkOutput("status5", {44'b0, status5}, e5.status);
        end else if (ack5 | nack5 | err5) begin
            nMiscompares++;
            $display("[TB] FAIL spurious5: got pulses %b, expected none", {ack5, nack5, err5});
        end
    end

    always @(posedge clk) begin
        #1;
        if (q8.size() > 0) begin
            e8 = q8.pop_front();
            checkOutput("pulses8", {61'b0, ack8, nack8, err8}, e8.pulses);
            checkOutput("status8", {24'b0, status8}, e8.status);
        end else if (ack8 | nack8 | err8) begin
            nMiscompares++;
            $display("[TB] FAIL spurious8: got pulses %b, expected none", {ack8, nack8, err8});
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 8; k++) mOwn[k] = '0;

        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 3, 1, 0, 3'b000, 20'h00000);
        applyStimulus(1, 1, 0, 0, 1, 0, 3'b100, 20'h00003);

        // Ownership: lower priority bounces, higher priority overrides.
        applyStimulus(1, 1, 2, 2, 1, 0, 3'b100, 20'h00B03);
        applyStimulus(1, 1, 2, 1, 0, 0, 3'b010, 20'h00B03);
        applyStimulus(1, 1, 2, 3, 0, 0, 3'b100, 20'h00E03);
        applyStimulus(1, 1, 6, 3, 1, 0, 3'b011, 20'h00E03);
        applyStimulus(1, 1, 5, 0, 1, 0, 3'b011, 20'h00E03);
        applyStimulus(1, 1, 1, 1, 1, 0, 3'b100, 20'h00E73);
        applyStimulus(1, 1, 4, 2, 1, 0, 3'b100, 20'hB0E73);
        applyStimulus(1, 1, 3, 3, 1, 1, 3'b010, 20'h00000);
        applyStimulus(1, 0, 0, 0, 0, 0, 3'b000, 20'h00000);

        // Hold window of 16 observed cycles, then expiry.
        applyStimulus(1, 1, 3, 1, 1, 0, 3'b100, 20'h07000);
        for (int i = 0; i < 14; i++) applyStimulus(1, 0, 0, 0, 0, 0, 3'b000, 20'h07000);
        applyStimulus(1, 1, 3, 0, 0, 0, 3'b010, 20'h07000);
        applyStimulus(1, 0, 0, 0, 0, 0, 3'b000, 20'h01000);
        applyStimulus(1, 1, 3, 0, 0, 0, 3'b100, 20'h02000);
        applyStimulus(1, 1, 3, 0, 1, 0, 3'b100, 20'h03000);
        applyStimulus(1, 0, 0, 0, 0, 1, 3'b000, 20'h00000);

        applyStimulus(1, 1, 0, 3, 1, 0, 3'b100, 20'h0000F);
        applyStimulus(0, 1, 0, 3, 1, 0, 3'b000, 20'h00000);
        applyStimulus(1, 0, 0, 0, 0, 0, 3'b000, 20'h00000);
        applyStimulus(1, 1, 0, 0, 1, 0, 3'b100, 20'h00003);
        applyStimulus(1, 0, 0, 0, 0, 1, 3'b000, 20'h00000);

        @(negedge clk);
        en5 = 1'b0; frc5 = 1'b0;

        for (int i = 0; i < 4; i++) applyRandom8(1, 3, 0, i[0], 0);
        for (int i = 0; i < 10000; i++) begin
            applyRandom8($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                         3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        en8 = 1'b0; frc8 = 1'b0;

        repeat (3) @(negedge clk);
        if (q5.size() != 0 || q8.size() != 0) begin
            nMiscompares++;
            $display("[TB] FAIL drain: got %0d/%0d pending, expected 0/0", q5.size(), q8.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiscompares);
        $finish;
    end

endmodule

// File: doc/prio_object_ctrl.md
Name: prio_object_ctrl

Overview:
- Parametrised successor to the fixed 5-object command/status controller.
- Accepts one on/off command per cycle for a selected object, tagged with a priority level.
- Enforces per-object ownership with a hold timer: a lower-priority request cannot override a recent higher-priority command.
- Drives a packed per-object status word to the system, plus a one-cycle accept/reject handshake and an emergency all-off input.

Parameters:
- N_OBJ, 5, number of controlled objects (1..16).
- LP_W, 2, priority width; a larger value means higher priority.
- HOLD_CYC, 16, cycles an object stays owned after an accepted command (0 = no hold).
- OBJ_W, $clog2(N_OBJ) min 1, object index width (derived).
- ST_W, 2+LP_W, status bits per object (derived).

Ports:
- clk_i  in  1  system clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- en_i  in  1  request valid, sampled each rising edge.
- object_number_i  in  OBJ_W  target object index.
- lp_i  in  LP_W  request priority.
- command_i  in  1  1 = on, 0 = off.
- force_off_i  in  1  emergency: all objects off, ownership cleared.
- ack_o  out  1  one-cycle pulse, request accepted.
- nack_o  out  1  one-cycle pulse, request rejected.
- err_o  out  1  one-cycle pulse, object index >= N_OBJ (asserted together with nack_o).
- status_o  out  N_OBJ*ST_W  per object k, slice [k*ST_W +: ST_W] = {owner_lp[LP_W-1:0], busy, on}.

Behaviour:
- Reset: rstn_i low asynchronously clears all registers. status_o = 0, ack_o = nack_o = err_o = 0, all hold counters = 0. Requests are ignored while in reset.
- Per-object state:
  - on bit.
  - owner_lp register (LP_W bits).
  - hold counter, width $clog2(HOLD_CYC+1), min 1.
  - busy = (counter != 0).
- Request sampled at edge k when en_i = 1. All outputs are registered; ack/nack/err and status change at edge k+1. Latency is exactly 1 cycle.
- Accept rule for object n < N_OBJ: !busy[n] OR lp_i >= owner_lp[n]. Equal priority while busy is accepted and re-arms the timer.
- On accept:
  - on[n] <= command_i.
  - owner_lp[n] <= lp_i.
  - counter[n] <= HOLD_CYC.
  - ack_o = 1 for one cycle.
- On reject (busy and lp_i < owner_lp): no state change, nack_o = 1 for one cycle.
- Index >= N_OBJ: nack_o = err_o = 1, no state change.
- en_i = 0: ack_o, nack_o and err_o are all 0.
- Hold timer:
  - Every non-loaded counter that is nonzero decrements by 1 per cycle. Loading takes precedence over decrementing in the same cycle.
  - When a counter reaches 0, owner_lp clears to 0 on that same edge.
  - on is unchanged by timer expiry.
  - After an accept at edge k+1, busy is 1 for edges k+1 .. k+HOLD_CYC and reads 0 from edge k+HOLD_CYC+1.
- HOLD_CYC = 0: busy is never set; every in-range request is accepted; owner_lp still shows the last accepted lp for one cycle, then clears.
- force_off_i = 1 at edge k: at k+1 all on, busy and owner_lp are 0. A simultaneous request is rejected with nack_o = 1 (err_o also 1 if out of range). force_off_i dominates both the request and timer activity.
- Only one object is updated per cycle. Timers of all other objects keep running independently.
- Asynchronous reset mid-hold clears the counter immediately; no pulse is pending after reset releases.

Test Plan:
- Reset/defaults: hold rstn_i = 0 for 3 cycles while driving en_i = 1 -> status_o = 0, ack/nack = 0 throughout; first request after release -> ack_o at +1 cycle.
- Ownership: obj 2, lp = 2, cmd = 1 -> ack; status slice 2 = {2'b10, 1, 1}. Next cycle obj 2, lp = 1, cmd = 0 -> nack, on stays 1. Same request with lp = 3 -> ack, on = 0, owner = 3.
- Timer expiry (HOLD_CYC = 16): accept at edge 10 -> busy observed at edges 11..26, owner = 0 and busy = 0 at edge 27. A lp = 0 request at edge 27 -> ack.
- Range error: object_number_i = 6 with N_OBJ = 5 -> nack_o = err_o = 1 for one cycle; status_o unchanged.
- Emergency: objects 0, 1, 4 on with busy = 1, then force_off_i with a simultaneous lp = 3 request -> nack; next cycle status_o = 0.
- Parametrisation: N_OBJ = 8, LP_W = 3, HOLD_CYC = 0 -> status_o width 40; back-to-back lp = 0 requests to the same object all ack; check against a cycle-accurate scoreboard under 10k cycles of random stimulus.
